// File: rtl/bfly_combine.sv
// Radix-2 butterfly combine stage: delays A to line up with the multiplier
// product P, then forms X = A + P and Y = A - P with optional halving or saturation.
module bfly_combine #(
    parameter int unsigned word_size = 16,
    parameter int unsigned DELAY     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [2*word_size-1:0]   A,
    input  logic                     p_valid,
    input  logic [2*word_size-1:0]   P,
    input  logic                     scale,
    input  logic                     clr_flags,
    output logic                     o_valid,
    output logic [2*word_size-1:0]   X,
    output logic [2*word_size-1:0]   Y,
    output logic                     ovf,
    output logic                     align_err
);

    localparam int unsigned W  = word_size;
    localparam int unsigned CW = 2 * word_size;
    localparam int unsigned SW = word_size + 1;

    logic [CW-1:0]    a_q [DELAY];
    logic [DELAY-1:0] v_q;

    logic [CW-1:0] ad;
    logic          vd;
    logic          fire;

    logic [SW-1:0] sum_xr, sum_xi, sum_yr, sum_yi;
    logic [W:0]    res_xr, res_xi, res_yr, res_yi;
    logic          sat_any;

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          o_valid_q, o_valid_d;
    logic          ovf_q, ovf_d;
    logic          aerr_q, aerr_d;

    // Sign-extend one component by a single bit so sums and differences are exact.
    function automatic logic [SW-1:0] sext(input logic [W-1:0] v);
        return {v[W-1], v};
    endfunction

    // Returns {clamp_active, result}: halve-with-round when scaling, else saturate.
    function automatic logic [W:0] lane(input logic [SW-1:0] s, input logic scl);
        logic [SW-1:0] rnd;
        logic [W-1:0]  val;
        logic          clamp;
        rnd   = s + SW'(1);
        val   = s[W-1:0];
        clamp = 1'b0;
        if (scl) begin
            val = rnd[SW-1:1];
        end else if (s[SW-1] != s[SW-2]) begin
            clamp = 1'b1;
            val   = s[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return {clamp, val};
    endfunction

    // Shift line runs every cycle so bubbles stay aligned with the multiplier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                a_q[i] <= '0;
            end
            v_q <= '0;
        end else begin
            a_q[0] <= A;
            v_q[0] <= i_valid;
            for (int i = 1; i < int'(DELAY); i++) begin
                a_q[i] <= a_q[i-1];
                v_q[i] <= v_q[i-1];
            end
        end
    end

    assign ad   = a_q[DELAY-1];
    assign vd   = v_q[DELAY-1];
    assign fire = vd & p_valid;

    always_comb begin
        sum_xr  = sext(ad[CW-1:W]) + sext(P[CW-1:W]);
        sum_xi  = sext(ad[W-1:0])  + sext(P[W-1:0]);
        sum_yr  = sext(ad[CW-1:W]) - sext(P[CW-1:W]);
        sum_yi  = sext(ad[W-1:0])  - sext(P[W-1:0]);
        res_xr  = lane(sum_xr, scale);
        res_xi  = lane(sum_xi, scale);
        res_yr  = lane(sum_yr, scale);
        res_yi  = lane(sum_yi, scale);
        sat_any = res_xr[W] | res_xi[W] | res_yr[W] | res_yi[W];
    end

    // Next-state for outputs and sticky flags; a set on the clear cycle wins.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        o_valid_d = fire;
        ovf_d     = (ovf_q & ~clr_flags) | (fire & ~scale & sat_any);
        aerr_d    = (aerr_q & ~clr_flags) | (vd ^ p_valid);
        if (fire) begin
            x_d = {res_xr[W-1:0], res_xi[W-1:0]};
            y_d = {res_yr[W-1:0], res_yi[W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            y_q       <= '0;
            o_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            aerr_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            o_valid_q <= o_valid_d;
            ovf_q     <= ovf_d;
            aerr_q    <= aerr_d;
        end
    end

    assign X         = x_q;
    assign Y         = y_q;
    assign o_valid   = o_valid_q;
    assign ovf       = ovf_q;
    assign align_err = aerr_q;

endmodule

// File: tb/tb_bfly_combine.sv
// Self-checking bench for bfly_combine: directed butterfly vectors plus
// randomized streams compared against an integer-arithmetic reference model.
module tb_bfly_combine;

    localparam int W = 16;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] A;
    logic        p_valid;
    logic [31:0] P;
    logic        scale;
    logic        clr_flags;
    logic        o_valid;
    logic [31:0] X;
    logic [31:0] Y;
    logic        ovf;
    logic        align_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: operands issued over the last D cycles plus expected outputs.
    bit          mv_q[$];
    logic [31:0] ma_q[$];
    bit          e_ov;
    logic [31:0] e_x;
    logic [31:0] e_y;
    bit          e_ovf;
    bit          e_aerr;

    bfly_combine #(.word_size(W), .DELAY(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .A         (A),
        .p_valid   (p_valid),
        .P         (P),
        .scale     (scale),
        .clr_flags (clr_flags),
        .o_valid   (o_valid),
        .X         (X),
        .Y         (Y),
        .ovf       (ovf),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // {clamped, value}: exact sum, then halve-with-round or clamp to 16-bit range.
    function automatic logic [16:0] ref_lane(input int a, input int b, input bit scl);
        int s;
        int r;
        bit c;
        s = a + b;
        c = 1'b0;
        if (scl) r = (s + 1) >>> 1;
        else if (s > 32767) begin r = 32767; c = 1'b1; end
        else if (s < -32768) begin r = -32768; c = 1'b1; end
        else r = s;
        return {c, r[15:0]};
    endfunction

    task automatic model_clear();
        mv_q   = {};
        ma_q   = {};
        for (int i = 0; i < D; i++) begin
            mv_q.push_back(1'b0);
            ma_q.push_back(32'h0);
        end
        e_ov   = 1'b0;
        e_x    = 32'h0;
        e_y    = 32'h0;
        e_ovf  = 1'b0;
        e_aerr = 1'b0;
    endtask

    // Drive one cycle, advance the model across the same edge, sample 1 time unit later.
    task automatic step(input bit iv, input logic [31:0] a, input bit pv,
                        input logic [31:0] p, input bit scl, input bit clr);
        bit          vd;
        logic [31:0] ad;
        logic [16:0] xr, xi, yr, yi;
        bit          sat;
        bit          fire;
        i_valid   = iv;
        A         = a;
        p_valid   = pv;
        P         = p;
        scale     = scl;
        clr_flags = clr;
        vd = mv_q[0];
        ad = ma_q[0];
        xr = ref_lane(s16(ad[31:16]),  s16(p[31:16]), scl);
        xi = ref_lane(s16(ad[15:0]),   s16(p[15:0]),  scl);
        yr = ref_lane(s16(ad[31:16]), -s16(p[31:16]), scl);
        yi = ref_lane(s16(ad[15:0]),  -s16(p[15:0]),  scl);
        sat  = xr[16] | xi[16] | yr[16] | yi[16];
        fire = vd && pv;
        e_ovf  = (e_ovf && !clr) || (fire && !scl && sat);
        e_aerr = (e_aerr && !clr) || (vd != pv);
        e_ov   = fire;
        if (fire) begin
            e_x = {xr[15:0], xi[15:0]};
            e_y = {yr[15:0], yi[15:0]};
        end
        void'(mv_q.pop_front());
        void'(ma_q.pop_front());
        mv_q.push_back(iv);
        ma_q.push_back(a);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_valid = 1'b0; A = '0; p_valid = 1'b0; P = '0; scale = 1'b0; clr_flags = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", o_valid); else n_pass++;
        n_checks++; if (X !== 32'h0) $display("FAIL reset_X: got %h expected 0", X); else n_pass++;
        n_checks++; if (Y !== 32'h0) $display("FAIL reset_Y: got %h expected 0", Y); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
        n_checks++; if (align_err !== 1'b0) $display("FAIL reset_align_err: got %b expected 0", align_err); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_scaled();
        step(1'b1, 32'h4000_2000, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < D - 1; i++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++; if (o_valid !== 1'b0) $display("FAIL scaled_early_valid: got %b expected 0", o_valid); else n_pass++;
        end
        step(1'b0, 32'h0, 1'b1, 32'h2000_E000, 1'b1, 1'b0);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL scaled_o_valid: got %b expected 1", o_valid); else n_pass++;
        n_checks++; if (X !== 32'h3000_0000) $display("FAIL scaled_X: got %h expected 30000000", X); else n_pass++;
        n_checks++; if (Y !== 32'h1000_2000) $display("FAIL scaled_Y: got %h expected 10002000", Y); else n_pass++;
        n_checks++; if (align_err !== 1'b0) $display("FAIL scaled_align_err: got %b expected 0", align_err); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (o_valid !== 1'b0 || X !== 32'h3000_0000) $display("FAIL scaled_hold: got v=%b X=%h expected v=0 X=30000000", o_valid, X); else n_pass++;
    endtask

    task automatic test_saturation();
        step(1'b1, 32'h7000_8000, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < D - 1; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h2000_9000, 1'b0, 1'b0);
        n_checks++; if (X !== 32'h7FFF_8000) $display("FAIL sat_X: got %h expected 7fff8000", X); else n_pass++;
        n_checks++; if (Y !== 32'h5000_F000) $display("FAIL sat_Y: got %h expected 5000f000", Y); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL sat_ovf: got %b expected 1", ovf); else n_pass++;
        repeat (3) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (ovf !== 1'b1) $display("FAIL sat_ovf_sticky: got %b expected 1", ovf); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (ovf !== 1'b0) $display("FAIL sat_ovf_clear: got %b expected 0", ovf); else n_pass++;
    endtask

    task automatic test_rounding();
        step(1'b1, 32'h0001_FFFF, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < D - 1; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        n_checks++; if (X !== 32'h0001_0000) $display("FAIL round_X: got %h expected 00010000", X); else n_pass++;
        n_checks++; if (Y !== 32'h0001_0000) $display("FAIL round_Y: got %h expected 00010000", Y); else n_pass++;
    endtask

    task automatic test_streaming();
        bit          sv[10];
        logic [31:0] sa[10];
        logic [31:0] sp[10];
        int          outs;
        int          beat;
        outs = 0;
        for (int i = 0; i < 10; i++) begin
            sv[i] = (i != 3) && (i != 6);
            sa[i] = $urandom();
            sp[i] = $urandom();
        end
        for (int t = 0; t < 10 + D + 1; t++) begin
            beat = t - D;
            step((t < 10) ? sv[t] : 1'b0, (t < 10) ? sa[t] : 32'h0,
                 (beat >= 0 && beat < 10) ? sv[beat] : 1'b0,
                 (beat >= 0 && beat < 10) ? sp[beat] : 32'h0,
                 1'($urandom_range(0, 1)), 1'b0);
            if (o_valid === 1'b1) outs++;
            n_checks++;
            if (o_valid !== e_ov || X !== e_x || Y !== e_y)
                $display("FAIL stream_t%0d: got v=%b X=%h Y=%h expected v=%b X=%h Y=%h", t, o_valid, X, Y, e_ov, e_x, e_y);
            else n_pass++;
        end
        n_checks++; if (outs != 8) $display("FAIL stream_count: got %0d expected 8", outs); else n_pass++;
        n_checks++; if (align_err !== 1'b0) $display("FAIL stream_align_err: got %b expected 0", align_err); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_misalign();
        step(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, (i == 0), 32'h1111_1111, 1'b0, 1'b0);
            n_checks++; if (o_valid !== 1'b0) $display("FAIL misalign_o_valid_%0d: got %b expected 0", i, o_valid); else n_pass++;
        end
        n_checks++; if (align_err !== 1'b1) $display("FAIL misalign_flag: got %b expected 1", align_err); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (align_err !== 1'b0) $display("FAIL misalign_clear: got %b expected 0", align_err); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 32'h0100_0200, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0300_0400, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || X !== 32'h0 || Y !== 32'h0 || ovf !== 1'b0 || align_err !== 1'b0)
            $display("FAIL midreset_async: got v=%b X=%h Y=%h ovf=%b aerr=%b expected all 0", o_valid, X, Y, ovf, align_err);
        else n_pass++;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, (i < 2), 32'h0005_0005, 1'b0, 1'b0);
            n_checks++; if (o_valid !== 1'b0) $display("FAIL midreset_stale_valid_%0d: got %b expected 0", i, o_valid); else n_pass++;
        end
        n_checks++; if (align_err !== e_aerr) $display("FAIL midreset_align_err: got %b expected %b", align_err, e_aerr); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        // First operand after release must be accepted normally.
        step(1'b1, 32'h0100_0100, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < D - 1; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0100_0100, 1'b0, 1'b0);
        n_checks++;
        if (o_valid !== 1'b1 || X !== 32'h0200_0200 || Y !== 32'h0)
            $display("FAIL postreset_op: got v=%b X=%h Y=%h expected v=1 X=02000200 Y=00000000", o_valid, X, Y);
        else n_pass++;
    endtask

    task automatic test_random();
        bit          pv_q[$];
        logic [31:0] pa_q[$];
        bit          iv;
        bit          pv;
        logic [31:0] a;
        logic [31:0] p;
        int          errs;
        errs = 0;
        for (int i = 0; i < D; i++) pv_q.push_back(1'b0);
        for (int t = 0; t < 400; t++) begin
            iv = ($urandom_range(0, 3) != 0);
            a  = $urandom();
            pv = pv_q.pop_front();
            if ($urandom_range(0, 29) == 0) pv = !pv;
            pv_q.push_back(iv);
            // Bias some products large so saturation is exercised.
            p = ($urandom_range(0, 2) == 0) ? 32'h7FFF_8000 ^ 32'($urandom_range(0, 255)) : $urandom();
            step(iv, a, pv, p, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            n_checks++;
            if (o_valid !== e_ov || X !== e_x || Y !== e_y || ovf !== e_ovf || align_err !== e_aerr) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_t%0d: got v=%b X=%h Y=%h ovf=%b aerr=%b expected v=%b X=%h Y=%h ovf=%b aerr=%b",
                             t, o_valid, X, Y, ovf, align_err, e_ov, e_x, e_y, e_ovf, e_aerr);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scaled();
        test_saturation();
        test_rounding();
        test_streaming();
        test_misalign();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bfly_combine.md
BFLY_COMBINE -- requirements
Module: bfly_combine

Interface
REQ-001 SHALL have parameter word_size, default 16, meaning bits per real/imag component (Q1.15 at default).
REQ-002 SHALL have parameter DELAY, default 3, meaning the cycle latency of the upstream complex multiplier that A is aligned against.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  A is valid this cycle; issued in the same cycle its partner B enters the multiplier.
REQ-006 A  input  2*word_size  butterfly top operand; real component in the upper half, imaginary in the lower half.
REQ-007 p_valid  input  1  multiplier product P is valid.
REQ-008 P  input  2*word_size  product W*B from the multiplier; same packing as A.
REQ-009 scale  input  1  1 = divide results by 2 with rounding; 0 = unscaled with saturation.
REQ-010 clr_flags  input  1  synchronous clear of the sticky flags.
REQ-011 o_valid  output  1  X and Y are valid.
REQ-012 X  output  2*word_size  A + P (scaled or saturated); same packing as A.
REQ-013 Y  output  2*word_size  A - P (scaled or saturated); same packing as A.
REQ-014 ovf  output  1  sticky flag: a saturation occurred.
REQ-015 align_err  output  1  sticky flag: p_valid disagreed with the delayed i_valid.

Function
REQ-016 SHALL delay A and i_valid by exactly DELAY cycles through an internal shift line, producing Ad and vd.
REQ-017 SHALL update the shift line every cycle, regardless of valid, so that pipeline bubbles are preserved.
REQ-018 SHALL form four (word_size+1)-bit signed sums each cycle: Ad.re±P.re and Ad.im±P.im.
REQ-019 When scale=1, each result SHALL be (sum+1)>>>1, truncated to word_size bits; this cannot overflow.
REQ-020 When scale=0, each result SHALL be the sum clamped to [-2^(word_size-1), 2^(word_size-1)-1].
REQ-021 With scale=0, ovf SHALL set when any clamp is active on a cycle where vd and p_valid are both 1.
REQ-022 X, Y and o_valid SHALL be registered outputs.
REQ-023 Latency SHALL be 1 cycle from p_valid to o_valid, which is DELAY+1 cycles from i_valid.
REQ-024 o_valid SHALL be registered as (vd AND p_valid).
REQ-025 X and Y SHALL hold their last value whenever o_valid is 0.
REQ-026 If vd differs from p_valid in any cycle, align_err SHALL set and o_valid SHALL be 0 for that cycle.
REQ-027 Back-to-back valids SHALL produce one output per cycle, with no stall capability and no ready signal.
REQ-028 scale SHALL be sampled in the cycle where vd and p_valid are both 1, not at i_valid.
REQ-029 clr_flags=1 SHALL clear ovf and align_err on the next edge.
REQ-030 If a set condition occurs in the same cycle as clr_flags, the set SHALL win.

Reset
REQ-031 On reset=0, SHALL asynchronously clear the shift line (data and valid), X, Y, o_valid, ovf and align_err to 0.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight operands; no o_valid may follow reset release without a new i_valid.
REQ-033 The first i_valid SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Scaled butterfly: scale=1, A=(0x4000,0x2000), P=(0x2000,0xE000) with p_valid DELAY cycles later -> one cycle later o_valid=1, X=(0x3000,0x0000), Y=(0x1000,0x2000).
REQ-035 Saturation: scale=0, A=(0x7000,0x8000), P=(0x2000,0x9000) -> X=(0x7FFF,0x8000), Y=(0x5000,0xF000), ovf=1 and ovf stays 1 until clr_flags.
REQ-036 Rounding: scale=1, A=(0x0001,0xFFFF), P=0 -> X=(0x0001,0x0000), Y=(0x0001,0x0000).
REQ-037 Streaming: 8 consecutive i_valid with gaps at beats 3 and 6, each P supplied at +DELAY -> 8 results in order, with o_valid gaps at the matching cycles.
REQ-038 Misalignment: p_valid pulsed 2 cycles after i_valid -> o_valid never asserts for that operand, align_err=1; clr_flags -> align_err=0.
REQ-039 Reset mid-stream: reset=0 for 1 cycle while 2 operands are in flight -> all outputs 0 immediately, and no o_valid afterwards even when their stale p_valid arrives.
